// File: rtl/fi_inject_ctrl.sv
// ---------------------------------------------------------------------------
// fi_inject_ctrl -- fault-injection run controller
//
// Runs one fault-injection experiment per command:
//   IDLE -> RESTORE -> INJECT -> RUN (N cycles) -> REPORT -> IDLE
// An illegal command skips straight from IDLE to REPORT with res_err set.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only in IDLE)
//   cmd_sel/mask/mode   target channel, fault bit mask, 0 flip/1 sa0/2 sa1
//   cmd_cycles          observation window N (0 is run as 1)
//   sig_in, golden_in   live and golden register values, channel i at
//                       [i*DATA_W +: DATA_W]
//   restore_en          DUT reloads golden state on this edge
//   ovr_en, ovr_val     per-channel override enable and override value
//   res_valid/ready     result handshake
//   res_diff            sig^golden of the target at the last observed cycle
//   res_any             any mismatch on any channel during the window
//   res_first           1-based RUN index of first mismatch, all-ones if none
//   res_masked          flip-mode run ended early because the fault vanished
//   res_err             illegal command (sel out of range or mode 3)
// ---------------------------------------------------------------------------

// Per-channel comparator: one instance per monitored register.
module fi_lane #(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] sig,
    input  logic [DATA_W-1:0] golden,
    output logic [DATA_W-1:0] diff,
    output logic              nz
);
    assign diff = sig ^ golden;
    assign nz   = |diff;
endmodule

module fi_inject_ctrl #(
    parameter int NUM_SIG    = 4,
    parameter int DATA_W     = 64,
    parameter int CNT_W      = 32,
    parameter int EARLY_EXIT = 1,
    localparam int SEL_W     = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [SEL_W-1:0]          cmd_sel,
    input  logic [DATA_W-1:0]         cmd_mask,
    input  logic [1:0]                cmd_mode,
    input  logic [CNT_W-1:0]          cmd_cycles,
    input  logic [NUM_SIG*DATA_W-1:0] sig_in,
    input  logic [NUM_SIG*DATA_W-1:0] golden_in,
    output logic                      restore_en,
    output logic [NUM_SIG-1:0]        ovr_en,
    output logic [DATA_W-1:0]         ovr_val,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DATA_W-1:0]         res_diff,
    output logic                      res_any,
    output logic [CNT_W-1:0]          res_first,
    output logic                      res_masked,
    output logic                      res_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_RESTORE, S_INJECT, S_RUN, S_REPORT
    } state_t;

    localparam logic [1:0] M_FLIP = 2'd0;
    localparam logic [1:0] M_SA0  = 2'd1;
    localparam logic [1:0] M_SA1  = 2'd2;
    localparam logic [1:0] M_BAD  = 2'd3;

    // One extra bit so NUM_SIG itself is representable for the range check.
    localparam logic [SEL_W:0] SEL_LIM = (SEL_W + 1)'(NUM_SIG);

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] mask;
        logic [1:0]        mode;
        logic [CNT_W-1:0]  n;
    } cmd_t;

    state_t                         state, state_nx;
    cmd_t                           cmd_q;
    logic [CNT_W-1:0]               k_q;

    logic [NUM_SIG-1:0][DATA_W-1:0] lane_diff;
    logic [NUM_SIG-1:0]             lane_nz;
    logic [DATA_W-1:0]              tgt_sig;
    logic [DATA_W-1:0]              tgt_diff;

    logic                           hs;
    logic                           cmd_bad;
    logic                           any_nz;
    logic                           last_k;
    logic                           early_exit;
    logic                           ovr_act;

    // ---------------------------------------------------------------
    // Per-channel comparators
    // ---------------------------------------------------------------
    for (genvar i = 0; i < NUM_SIG; i++) begin : g_lane
        fi_lane #(.DATA_W(DATA_W)) u_lane (
            .sig    (sig_in[i*DATA_W +: DATA_W]),
            .golden (golden_in[i*DATA_W +: DATA_W]),
            .diff   (lane_diff[i]),
            .nz     (lane_nz[i])
        );
    end

    // Target-channel select; loop compare keeps non-power-of-two
    // NUM_SIG free of out-of-range indexing.
    always_comb begin
        tgt_sig  = '0;
        tgt_diff = '0;
        for (int i = 0; i < NUM_SIG; i++) begin
            if (cmd_q.sel == SEL_W'(i)) begin
                tgt_sig  = sig_in[i*DATA_W +: DATA_W];
                tgt_diff = lane_diff[i];
            end
        end
    end

    assign hs      = cmd_valid && cmd_ready;
    assign cmd_bad = ({1'b0, cmd_sel} >= SEL_LIM) || (cmd_mode == M_BAD);
    assign any_nz  = |lane_nz;
    assign last_k  = (k_q == cmd_q.n);

    // Fault is considered masked when a flip run has already seen a
    // mismatch and every channel now agrees with golden again. k>=2
    // guarantees at least one earlier observed cycle.
    assign early_exit = (EARLY_EXIT != 0) && (state == S_RUN) &&
                        (cmd_q.mode == M_FLIP) && (k_q >= CNT_W'(2)) &&
                        res_any && !any_nz;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // ---------------------------------------------------------------
    // FSM: next state and outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        cmd_ready  = 1'b0;
        restore_en = 1'b0;
        res_valid  = 1'b0;
        ovr_act    = 1'b0;
        ovr_en     = '0;
        ovr_val    = '0;

        case (state)
            S_IDLE: begin
                cmd_ready = !rst;
                if (hs) state_nx = cmd_bad ? S_REPORT : S_RESTORE;
            end
            S_RESTORE: begin
                restore_en = 1'b1;
                state_nx   = S_INJECT;
            end
            S_INJECT: begin
                ovr_act  = 1'b1;
                state_nx = S_RUN;
            end
            S_RUN: begin
                // Stuck faults must be re-forced every cycle; a flip is a
                // one-shot upset and is left alone after INJECT.
                ovr_act = (cmd_q.mode != M_FLIP);
                if (early_exit || last_k) state_nx = S_REPORT;
            end
            S_REPORT: begin
                res_valid = 1'b1;
                if (res_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        // Gate with rst so the override releases the instant reset rises.
        if (ovr_act && !rst) begin
            for (int i = 0; i < NUM_SIG; i++)
                ovr_en[i] = (cmd_q.sel == SEL_W'(i));
            case (cmd_q.mode)
                M_SA0:   ovr_val = tgt_sig & ~cmd_q.mask;
                M_SA1:   ovr_val = tgt_sig |  cmd_q.mask;
                default: ovr_val = tgt_sig ^  cmd_q.mask;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Command latch, window counter and result record
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q      <= '0;
            k_q        <= '0;
            res_diff   <= '0;
            res_any    <= 1'b0;
            res_first  <= '1;
            res_masked <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        cmd_q.sel  <= cmd_sel;
                        cmd_q.mask <= cmd_mask;
                        cmd_q.mode <= cmd_mode;
                        cmd_q.n    <= (cmd_cycles == '0) ? CNT_W'(1) : cmd_cycles;
                        // Clearing here covers both the RESTORE entry and
                        // the direct-to-REPORT illegal path.
                        res_diff   <= '0;
                        res_any    <= 1'b0;
                        res_first  <= '1;
                        res_masked <= 1'b0;
                        res_err    <= cmd_bad;
                    end
                end
                S_INJECT: k_q <= CNT_W'(1);
                S_RUN: begin
                    if (any_nz && !res_any) begin
                        res_any   <= 1'b1;
                        res_first <= k_q;
                    end
                    if (early_exit) begin
                        res_masked <= 1'b1;
                        res_diff   <= '0;
                    end else begin
                        res_diff <= tgt_diff;
                    end
                    // Stop at N so a full-range window never wraps.
                    if (!last_k) k_q <= k_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
